// File: rtl/gs_dac_sdm.sv
// gs_dac_sdm: General Sound DAC output stage (clk32 domain).
// Snoops the GS CPU bus for DAC sample reads and volume port writes,
// scales the four channels with one shared 8-cycle shift-add multiplier,
// and drives four first-order sigma-delta bitstreams.

// One sigma-delta lane: accumulate the scaled sample once per frame and
// emit the carry as the output bit.
module gs_dac_sdm_lane #(
    parameter int ACC_W = 14
) (
    input  logic             clk32,
    input  logic             rst_n,
    input  logic             upd_i,
    input  logic [ACC_W-1:0] prod_i,
    output logic             gdac_o
);
    logic [ACC_W-1:0] acc_q;
    logic             gdac_q;
    logic [ACC_W:0]   sum;

    assign sum    = {1'b0, acc_q} + {1'b0, prod_i};
    assign gdac_o = gdac_q;

    // Accumulator and output bit update only in this lane's phase-7 slot.
    always_ff @(posedge clk32 or negedge rst_n) begin
        if (!rst_n) begin
            acc_q  <= '0;
            gdac_q <= 1'b0;
        end else if (upd_i) begin
            acc_q  <= sum[ACC_W-1:0];
            gdac_q <= sum[ACC_W];
        end
    end
endmodule

module gs_dac_sdm #(
    parameter int DAC_W = 8,
    parameter int VOL_W = 6,
    parameter int ACC_W = 14   // must equal DAC_W+VOL_W (product width)
) (
    input  logic        clk32,
    input  logic        rst_n,
    input  logic [15:0] ga,
    input  logic [7:0]  gd,
    input  logic        n_gmreq,
    input  logic        n_giorq,
    input  logic        n_grd,
    input  logic        n_gwr,
    input  logic        n_gm1,
    output logic        gdac0,
    output logic        gdac1,
    output logic        gdac2,
    output logic        gdac3,
    output logic        frame
);
    localparam int NUM_CH = 4;

    // ---------------- bus snoop stage S1 ----------------
    logic [15:0] ga_q;
    logic [7:0]  gd_q;
    logic        n_gmreq_q, n_giorq_q, n_grd_q, n_gwr_q, n_gm1_q;

    // Register every bus input once; all decoding works on these copies.
    always_ff @(posedge clk32 or negedge rst_n) begin
        if (!rst_n) begin
            ga_q      <= '0;
            gd_q      <= '0;
            n_gmreq_q <= 1'b1;
            n_giorq_q <= 1'b1;
            n_grd_q   <= 1'b1;
            n_gwr_q   <= 1'b1;
            n_gm1_q   <= 1'b1;
        end else begin
            ga_q      <= ga;
            gd_q      <= gd;
            n_gmreq_q <= n_gmreq;
            n_giorq_q <= n_giorq;
            n_grd_q   <= n_grd;
            n_gwr_q   <= n_gwr;
            n_gm1_q   <= n_gm1;
        end
    end

    // ---------------- access decode ----------------
    logic       rd_hit, wr_hit;
    logic [3:0] wr_idx;

    assign rd_hit = ~n_gmreq_q & ~n_grd_q & (ga_q[15:13] == 3'b011);
    assign wr_hit = ~n_giorq_q & ~n_gwr_q & n_gm1_q
                  & (ga_q[3:0] >= 4'd6) & (ga_q[3:0] <= 4'd9);
    assign wr_idx = ga_q[3:0] - 4'd6;

    // ---------------- glitch filters ----------------
    // A hit must last at least two cycles; the held value is committed on
    // the first cycle the hit drops.
    logic [1:0] rd_run_q, rd_run_d, wr_run_q, wr_run_d;
    logic [7:0] rd_hold_q, wr_hold_q;
    logic [1:0] rd_ch_q, wr_ch_q;
    logic       rd_commit, wr_commit;

    assign rd_commit = ~rd_hit & rd_run_q[1];
    assign wr_commit = ~wr_hit & wr_run_q[1];

    // Saturating run counters for both access paths.
    always_comb begin
        rd_run_d = '0;
        wr_run_d = '0;
        if (rd_hit) rd_run_d = (rd_run_q == 2'd3) ? 2'd3 : rd_run_q + 2'd1;
        if (wr_hit) wr_run_d = (wr_run_q == 2'd3) ? 2'd3 : wr_run_q + 2'd1;
    end

    // Run counters plus data/channel hold registers, tracked while a hit lasts.
    always_ff @(posedge clk32 or negedge rst_n) begin
        if (!rst_n) begin
            rd_run_q  <= '0;
            wr_run_q  <= '0;
            rd_hold_q <= '0;
            wr_hold_q <= '0;
            rd_ch_q   <= '0;
            wr_ch_q   <= '0;
        end else begin
            rd_run_q <= rd_run_d;
            wr_run_q <= wr_run_d;
            if (rd_hit) begin
                rd_hold_q <= gd_q;
                rd_ch_q   <= ga_q[9:8];
            end
            if (wr_hit) begin
                wr_hold_q <= gd_q;
                wr_ch_q   <= wr_idx[1:0];
            end
        end
    end

    // ---------------- channel registers ----------------
    logic [NUM_CH-1:0][DAC_W-1:0] smp_q;
    logic [NUM_CH-1:0][VOL_W-1:0] vol_q;

    // Sample and volume commits are independent and may land together.
    always_ff @(posedge clk32 or negedge rst_n) begin
        if (!rst_n) begin
            smp_q <= '0;
            vol_q <= '0;
        end else begin
            if (rd_commit) smp_q[rd_ch_q] <= rd_hold_q[DAC_W-1:0];
            if (wr_commit) vol_q[wr_ch_q] <= wr_hold_q[VOL_W-1:0];
        end
    end

    // ---------------- frame timing ----------------
    logic [4:0] cnt_q;
    logic [1:0] slot;
    logic [2:0] phase;

    assign slot  = cnt_q[4:3];
    assign phase = cnt_q[2:0];
    assign frame = (cnt_q == 5'd31);

    // Free-running 32-cycle frame counter.
    always_ff @(posedge clk32 or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_q + 5'd1;
    end

    // ---------------- shared shift-add multiplier ----------------
    logic [DAC_W-1:0] op_a_q, op_a_d;
    logic [VOL_W-1:0] op_b_q, op_b_d;
    logic [ACC_W-1:0] prod_q, prod_d;
    logic [2:0]       sh;

    assign sh = phase - 3'd1;

    // Phase 0 loads operands, phases 1..6 add one partial product each
    // (volume LSB first), phase 7 holds the result for the lane update.
    always_comb begin
        op_a_d = op_a_q;
        op_b_d = op_b_q;
        prod_d = prod_q;
        case (phase)
            3'd0: begin
                op_a_d = smp_q[slot];
                op_b_d = vol_q[slot];
                prod_d = '0;
            end
            3'd7: ;
            default: begin
                if (op_b_q[0]) prod_d = prod_q + ({{VOL_W{1'b0}}, op_a_q} << sh);
                op_b_d = op_b_q >> 1;
            end
        endcase
    end

    // Multiplier datapath registers.
    always_ff @(posedge clk32 or negedge rst_n) begin
        if (!rst_n) begin
            op_a_q <= '0;
            op_b_q <= '0;
            prod_q <= '0;
        end else begin
            op_a_q <= op_a_d;
            op_b_q <= op_b_d;
            prod_q <= prod_d;
        end
    end

    // ---------------- sigma-delta lanes ----------------
    logic [NUM_CH-1:0] gdac_v;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_lane
        gs_dac_sdm_lane #(.ACC_W(ACC_W)) u_lane (
            .clk32  (clk32),
            .rst_n  (rst_n),
            .upd_i  ((phase == 3'd7) && (slot == i)),
            .prod_i (prod_q),
            .gdac_o (gdac_v[i])
        );
    end

    assign gdac0 = gdac_v[0];
    assign gdac1 = gdac_v[1];
    assign gdac2 = gdac_v[2];
    assign gdac3 = gdac_v[3];

    // Address/data bits the decode never looks at.
    logic unused_bits;
    assign unused_bits = ^{ga_q[12:10], ga_q[7:4], wr_hold_q[7:6], wr_idx[3:2]};
endmodule

// File: tb/tb_gs_dac_sdm.sv
// tb_gs_dac_sdm: directed, table-driven checks of the GS DAC output stage.
module tb_gs_dac_sdm;
    logic        clk32 = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] ga;
    logic [7:0]  gd;
    logic        n_gmreq, n_giorq, n_grd, n_gwr, n_gm1;
    logic        g0, g1, g2, g3, frame;
    logic [3:0]  gdac;
    logic [4:0]  tcnt;

    int n_chk  = 0;
    int n_pass = 0;

    typedef struct {
        int          ch;
        logic [3:0]  port;
        logic [7:0]  vold;
        logic        m1;
        logic [15:0] addr;
        logic [7:0]  smpd;
        int          rdlen;
        logic        simul;
        int          nfr;
        int          exp_ones;
    } vec_t;

    vec_t tbl[12];

    gs_dac_sdm dut (
        .clk32   (clk32),
        .rst_n   (rst_n),
        .ga      (ga),
        .gd      (gd),
        .n_gmreq (n_gmreq),
        .n_giorq (n_giorq),
        .n_grd   (n_grd),
        .n_gwr   (n_gwr),
        .n_gm1   (n_gm1),
        .gdac0   (g0),
        .gdac1   (g1),
        .gdac2   (g2),
        .gdac3   (g3),
        .frame   (frame)
    );

    assign gdac = {g3, g2, g1, g0};

    always #5 clk32 = ~clk32;

    // Expected position within the 32-cycle frame.
    always @(posedge clk32 or negedge rst_n) begin
        if (!rst_n) tcnt <= '0;
        else        tcnt <= tcnt + 5'd1;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d required %0d", name, act, exp);
    endtask

    task automatic tick();
        @(negedge clk32);
    endtask

    task automatic bus_idle();
        ga = '0; gd = '0;
        n_gmreq = 1'b1; n_giorq = 1'b1; n_grd = 1'b1; n_gwr = 1'b1; n_gm1 = 1'b1;
    endtask

    task automatic reset_dut();
        rst_n = 1'b0;
        bus_idle();
        repeat (3) tick();
        rst_n = 1'b1;
    endtask

    task automatic wait_cnt(input int v);
        int n = 0;
        while (tcnt != v[4:0] && n < 64) begin
            tick();
            n++;
        end
        if (n >= 64) chk("wait_cnt_timeout", n, 0);
    endtask

    task automatic io_wr(input logic [3:0] port, input logic [7:0] d, input int len, input logic m1);
        ga = {12'h000, port}; gd = d;
        n_giorq = 1'b0; n_gwr = 1'b0; n_gm1 = m1;
        repeat (len) tick();
        bus_idle();
        repeat (3) tick();
    endtask

    task automatic mem_rd(input logic [15:0] a, input logic [7:0] d, input int len);
        ga = a; gd = d;
        n_gmreq = 1'b0; n_grd = 1'b0;
        repeat (len) tick();
        bus_idle();
        repeat (3) tick();
    endtask

    // Bus ops start just after the channel's load slot, so the new values
    // are loaded on the next frame; returns at the first visible output bit.
    task automatic program_case(input vec_t r);
        wait_cnt(r.ch * 8 + 1);
        if (r.simul) begin
            ga = r.addr; gd = r.smpd;
            n_gmreq = 1'b0; n_grd = 1'b0;
            n_giorq = 1'b0; n_gwr = 1'b0; n_gm1 = r.m1;
            repeat (r.rdlen) tick();
            bus_idle();
            repeat (3) tick();
        end else begin
            io_wr(r.port, r.vold, 2, r.m1);
            mem_rd(r.addr, r.smpd, r.rdlen);
        end
        wait_cnt(r.ch * 8);
        repeat (8) tick();
    endtask

    task automatic idle_scan(input int ncyc, output int first, output int fmis, output int ones);
        first = -1; fmis = 0; ones = 0;
        for (int i = 0; i < ncyc; i++) begin
            if (frame && first < 0) first = i;
            if (frame != (tcnt == 5'd31)) fmis++;
            if (gdac != 4'd0) ones++;
            tick();
        end
    endtask

    initial begin
        int first, fmis, ones, others;
        logic [3:0] pat;
        vec_t r;

        //          ch port vold   m1    addr      smpd  len simul nfr  exp
        tbl[0]  = '{0, 4'h6, 8'h3F, 1'b1, 16'h6000, 8'hFF, 3, 1'b0, 1024, 1004};
        tbl[1]  = '{2, 4'h8, 8'h20, 1'b1, 16'h6200, 8'h80, 3, 1'b0,   16,    4};
        tbl[2]  = '{1, 4'h7, 8'h3F, 1'b1, 16'h6100, 8'hFF, 1, 1'b0,   16,    0};
        tbl[3]  = '{1, 4'h7, 8'h3F, 1'b1, 16'h6100, 8'hFF, 2, 1'b0,   16,   15};
        tbl[4]  = '{3, 4'h9, 8'hFF, 1'b1, 16'h6300, 8'h40, 3, 1'b0,   64,   15};
        tbl[5]  = '{0, 4'h6, 8'h3F, 1'b0, 16'h6000, 8'hFF, 3, 1'b0,   32,    0};
        tbl[6]  = '{0, 4'h6, 8'hC1, 1'b1, 16'h6000, 8'h80, 3, 1'b0,  128,    1};
        tbl[7]  = '{2, 4'h8, 8'h3F, 1'b1, 16'h6200, 8'h00, 3, 1'b0,   32,    0};
        tbl[8]  = '{2, 4'h8, 8'h3F, 1'b1, 16'h8200, 8'hFF, 3, 1'b0,   32,    0};
        tbl[9]  = '{0, 4'h6, 8'h00, 1'b1, 16'h6006, 8'h3F, 3, 1'b1,   64,   15};
        tbl[10] = '{1, 4'h5, 8'h3F, 1'b1, 16'h6100, 8'hFF, 3, 1'b0,   32,    0};
        tbl[11] = '{3, 4'h9, 8'h10, 1'b1, 16'h7F00, 8'hFF, 3, 1'b0,   64,   15};

        // Reset state, then idle frames: outputs quiet, frame on cycle 31.
        bus_idle();
        repeat (3) tick();
        chk("rst_gdac", int'(gdac), 0);
        chk("rst_frame", int'(frame), 0);
        rst_n = 1'b1;
        idle_scan(256 * 32, first, fmis, ones);
        chk("idle_first_frame", first, 31);
        chk("idle_frame_timing", fmis, 0);
        chk("idle_gdac_ones", ones, 0);

        // Table: ones count over N frames on the target channel.
        for (int k = 0; k < 12; k++) begin
            reset_dut();
            program_case(tbl[k]);
            ones = 0; others = 0;
            for (int f = 0; f < tbl[k].nfr; f++) begin
                ones += int'(gdac[tbl[k].ch]);
                for (int c = 0; c < 4; c++)
                    if (c != tbl[k].ch) others += int'(gdac[c]);
                repeat (32) tick();
            end
            chk($sformatf("vec%0d_ones_ch%0d", k, tbl[k].ch), ones, tbl[k].exp_ones);
            chk($sformatf("vec%0d_other_ch", k), others, 0);
        end

        // prod 4096 on channel 2: bit pattern 0,0,0,1,0,0,0,1.
        reset_dut();
        program_case(tbl[1]);
        for (int f = 0; f < 8; f++) begin
            chk($sformatf("ch2_pattern_f%0d", f + 1), int'(g2), (f % 4 == 3) ? 1 : 0);
            repeat (32) tick();
        end

        // Mid-frame reset with channel 0 at full scale.
        reset_dut();
        program_case(tbl[0]);
        repeat (69) tick();
        chk("pre_rst_gdac0", int'(g0), 1);
        chk("pre_rst_cycle", int'(tcnt), 13);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_gdac", int'(gdac), 0);
        chk("async_rst_frame", int'(frame), 0);
        repeat (2) tick();
        rst_n = 1'b1;
        idle_scan(64, first, fmis, ones);
        chk("post_rst_first_frame", first, 31);
        chk("post_rst_gdac_ones", ones, 0);
        // Accumulator must restart from 0: prod 4096 gives 0,0,0,1.
        r = '{0, 4'h6, 8'h20, 1'b1, 16'h6000, 8'h80, 3, 1'b0, 4, 1};
        program_case(r);
        pat = '0;
        for (int f = 0; f < 4; f++) begin
            pat[f] = g0;
            repeat (32) tick();
        end
        chk("post_rst_ch0_pattern", int'(pat), 4'b1000);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
